// File: rtl/id_operand_stage_pkg.sv
// Shared constants, opcode encodings and field positions for the decode/operand-fetch stage.
package id_operand_stage_pkg;

    localparam int DW    = 12;
    localparam int AW    = 3;
    localparam int NREG  = 8;
    localparam int IMM_W = 6;

    localparam int OP_HI  = 11;
    localparam int OP_LO  = 9;
    localparam int RD_HI  = 8;
    localparam int RD_LO  = 6;
    localparam int RS1_HI = 5;
    localparam int RS1_LO = 3;
    localparam int RS2_HI = 2;
    localparam int RS2_LO = 0;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_LDI = 3'b101,
        OP_LD  = 3'b110,
        OP_ST  = 3'b111
    } opcode_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic wen;
        logic is_imm;
    } dec_t;

    function automatic dec_t decode_op(input logic [2:0] op);
        dec_t d;
        d = '{uses_rs1: 1'b0, uses_rs2: 1'b0, wen: 1'b0, is_imm: 1'b0};
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: d = '{uses_rs1: 1'b1, uses_rs2: 1'b1, wen: 1'b1, is_imm: 1'b0};
            OP_LDI:                        d = '{uses_rs1: 1'b0, uses_rs2: 1'b0, wen: 1'b1, is_imm: 1'b1};
            OP_LD:                         d = '{uses_rs1: 1'b1, uses_rs2: 1'b0, wen: 1'b1, is_imm: 1'b0};
            OP_ST:                         d = '{uses_rs1: 1'b1, uses_rs2: 1'b1, wen: 1'b0, is_imm: 1'b0};
            default:                       d = '{uses_rs1: 1'b0, uses_rs2: 1'b0, wen: 1'b0, is_imm: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Fetch, register-file, execute and writeback signals of the operand stage.
interface id_operand_stage_if;
    import id_operand_stage_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_instr;
    logic          rf_read2;
    logic [AW-1:0] rf_adr2;
    logic [DW-1:0] rf_data2;
    logic          rf_read3;
    logic [AW-1:0] rf_adr3;
    logic [DW-1:0] rf_data3;
    logic          ex_valid;
    logic          ex_ready;
    logic [2:0]    ex_op;
    logic [AW-1:0] ex_rd;
    logic          ex_wen;
    logic [DW-1:0] ex_opa;
    logic [DW-1:0] ex_opb;
    logic          wb_valid;
    logic [AW-1:0] wb_adr;
    logic [NREG-1:0] sb_busy;

    modport master (
        output in_valid, in_instr, rf_data2, rf_data3, ex_ready, wb_valid, wb_adr,
        input  in_ready, rf_read2, rf_adr2, rf_read3, rf_adr3,
               ex_valid, ex_op, ex_rd, ex_wen, ex_opa, ex_opb, sb_busy
    );

    modport slave (
        input  in_valid, in_instr, rf_data2, rf_data3, ex_ready, wb_valid, wb_adr,
        output in_ready, rf_read2, rf_adr2, rf_read3, rf_adr3,
               ex_valid, ex_op, ex_rd, ex_wen, ex_opa, ex_opb, sb_busy
    );

endinterface

// File: rtl/id_scoreboard.sv
// Pending-write bits per register with set/clear and a three-source hazard lookup.
module id_scoreboard
    import id_operand_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [AW-1:0]   set_adr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_adr,
    input  logic            chk1_en,
    input  logic [AW-1:0]   chk1_adr,
    input  logic            chk2_en,
    input  logic [AW-1:0]   chk2_adr,
    input  logic            chk3_en,
    input  logic [AW-1:0]   chk3_adr,
    output logic            hazard,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;

    // One-hot set/clear masks; set is OR-ed after the clear so it wins on a collision.
    always_comb begin
        set_mask_s = {NREG{1'b0}};
        clr_mask_s = {NREG{1'b0}};
        if (set_en) begin
            set_mask_s[set_adr] = 1'b1;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        if (clr_en) begin
            clr_mask_s[clr_adr] = 1'b1;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
    end

    // Pending bits register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Lookup uses the registered bits only, so a clear is seen one cycle after wb.
    assign hazard = (chk1_en && busy_r[chk1_adr]) ||
                    (chk2_en && busy_r[chk2_adr]) ||
                    (chk3_en && busy_r[chk3_adr]);
    assign busy   = busy_r;

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: regfile read, hazard stall and the ID/EX pipeline register.
module id_operand_stage
    import id_operand_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    id_operand_stage_if.slave  bus
);

    logic [2:0]      op_s;
    logic [AW-1:0]   rd_s;
    logic [AW-1:0]   rs1_s;
    logic [AW-1:0]   rs2_s;
    dec_t            dec_s;
    logic            read2_s;
    logic            read3_s;
    logic [DW-1:0]   opa_s;
    logic [DW-1:0]   opb_s;
    logic            stall_s;
    logic            in_ready_s;
    logic            accept_s;
    logic [NREG-1:0] sb_busy_s;

    logic            ex_valid_r;
    logic [2:0]      ex_op_r;
    logic [AW-1:0]   ex_rd_r;
    logic            ex_wen_r;
    logic [DW-1:0]   ex_opa_r;
    logic [DW-1:0]   ex_opb_r;

    assign op_s  = bus.in_instr[OP_HI:OP_LO];
    assign rd_s  = bus.in_instr[RD_HI:RD_LO];
    assign rs1_s = bus.in_instr[RS1_HI:RS1_LO];
    assign rs2_s = bus.in_instr[RS2_HI:RS2_LO];
    assign dec_s = decode_op(op_s);

    // Read enables and operand selection; unused operands are forced to zero.
    always_comb begin
        read2_s = 1'b0;
        read3_s = 1'b0;
        opa_s   = {DW{1'b0}};
        opb_s   = {DW{1'b0}};
        if (bus.in_valid) begin
            read2_s = dec_s.uses_rs1;
            read3_s = dec_s.uses_rs2;
        end else begin
            read2_s = 1'b0;
            read3_s = 1'b0;
        end
        if (dec_s.uses_rs1) begin
            opa_s = bus.rf_data2;
        end else begin
            opa_s = {DW{1'b0}};
        end
        if (dec_s.is_imm) begin
            opb_s = {{(DW-IMM_W){1'b0}}, bus.in_instr[IMM_W-1:0]};
        end else if (dec_s.uses_rs2) begin
            opb_s = bus.rf_data3;
        end else begin
            opb_s = {DW{1'b0}};
        end
    end

    id_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (accept_s && dec_s.wen),
        .set_adr  (rd_s),
        .clr_en   (bus.wb_valid),
        .clr_adr  (bus.wb_adr),
        .chk1_en  (bus.in_valid && dec_s.uses_rs1),
        .chk1_adr (rs1_s),
        .chk2_en  (bus.in_valid && dec_s.uses_rs2),
        .chk2_adr (rs2_s),
        .chk3_en  (bus.in_valid && dec_s.wen),
        .chk3_adr (rd_s),
        .hazard   (stall_s),
        .busy     (sb_busy_s)
    );

    assign in_ready_s = !stall_s && (!ex_valid_r || bus.ex_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    // ID/EX pipeline register: load on accept, drain on consume, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_op_r    <= 3'b000;
            ex_rd_r    <= {AW{1'b0}};
            ex_wen_r   <= 1'b0;
            ex_opa_r   <= {DW{1'b0}};
            ex_opb_r   <= {DW{1'b0}};
        end else if (accept_s) begin
            ex_valid_r <= 1'b1;
            ex_op_r    <= op_s;
            ex_rd_r    <= rd_s;
            ex_wen_r   <= dec_s.wen;
            ex_opa_r   <= opa_s;
            ex_opb_r   <= opb_s;
        end else if (bus.ex_ready) begin
            ex_valid_r <= 1'b0;
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.rf_read2 = read2_s;
    assign bus.rf_adr2  = rs1_s;
    assign bus.rf_read3 = read3_s;
    assign bus.rf_adr3  = rs2_s;
    assign bus.ex_valid = ex_valid_r;
    assign bus.ex_op    = ex_op_r;
    assign bus.ex_rd    = ex_rd_r;
    assign bus.ex_wen   = ex_wen_r;
    assign bus.ex_opa   = ex_opa_r;
    assign bus.ex_opb   = ex_opb_r;
    assign bus.sb_busy  = sb_busy_s;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench: table of single-op vectors plus hazard, backpressure and reset sequences.
module tb_id_operand_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_operand_stage_if bus ();

    id_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [11:0] regs [8];
    always_comb bus.rf_data2 = regs[bus.rf_adr2];
    always_comb bus.rf_data3 = regs[bus.rf_adr3];

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic        wen;
        logic [11:0] opa;
        logic [11:0] opb;
    } exp_t;

    typedef struct {
        logic [11:0] instr;
        logic        r2;
        logic        r3;
        logic [2:0]  op;
        logic [2:0]  rd;
        logic        wen;
        logic [11:0] opa;
        logic [11:0] opb;
    } vec_t;

    exp_t q[$];
    vec_t vecs [8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [2:0] rd, input logic wen,
                        input logic [11:0] opa, input logic [11:0] opb);
        exp_t e;
        e.op = op; e.rd = rd; e.wen = wen; e.opa = opa; e.opb = opb;
        q.push_back(e);
    endtask

    task automatic check_ex(input string tag);
        exp_t e;
        chk({tag, ".ex_valid"}, {31'd0, bus.ex_valid}, 32'd1);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.queue: got empty expected an entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".ex_op"},  {29'd0, bus.ex_op},  {29'd0, e.op});
            chk({tag, ".ex_rd"},  {29'd0, bus.ex_rd},  {29'd0, e.rd});
            chk({tag, ".ex_wen"}, {31'd0, bus.ex_wen}, {31'd0, e.wen});
            chk({tag, ".ex_opa"}, {20'd0, bus.ex_opa}, {20'd0, e.opa});
            chk({tag, ".ex_opb"}, {20'd0, bus.ex_opb}, {20'd0, e.opb});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        logic [7:0] m;
        regs[0] = 12'h111; regs[1] = 12'h00A; regs[2] = 12'h005; regs[3] = 12'h333;
        regs[4] = 12'h444; regs[5] = 12'h555; regs[6] = 12'h666; regs[7] = 12'h7FF;
        bus.in_valid = 1'b0;
        bus.in_instr = 12'h000;
        bus.ex_ready = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_adr   = 3'd0;

        //            instr     rd2   rd3   op    rd    wen   opa      opb
        vecs[0] = '{12'h2CA, 1'b1, 1'b1, 3'd1, 3'd3, 1'b1, 12'h00A, 12'h005}; // ADD r3,r1,r2
        vecs[1] = '{12'hB2A, 1'b0, 1'b0, 3'd5, 3'd4, 1'b1, 12'h000, 12'h02A}; // LDI r4,#2A
        vecs[2] = '{12'h577, 1'b1, 1'b1, 3'd2, 3'd5, 1'b1, 12'h666, 12'h7FF}; // SUB r5,r6,r7
        vecs[3] = '{12'h638, 1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 12'h7FF, 12'h111}; // AND r0,r7,r0
        vecs[4] = '{12'h9E5, 1'b1, 1'b1, 3'd4, 3'd7, 1'b1, 12'h444, 12'h555}; // OR r7,r4,r5
        vecs[5] = '{12'hC53, 1'b1, 1'b0, 3'd6, 3'd1, 1'b1, 12'h005, 12'h000}; // LD r1,r2
        vecs[6] = '{12'hF9C, 1'b1, 1'b1, 3'd7, 3'd6, 1'b0, 12'h333, 12'h444}; // ST r3,r4
        vecs[7] = '{12'h1FF, 1'b0, 1'b0, 3'd0, 3'd7, 1'b0, 12'h000, 12'h000}; // NOP

        do_reset();
        #1;
        chk("rst.ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst.ex_opa",   {20'd0, bus.ex_opa},   32'd0);
        chk("rst.ex_opb",   {20'd0, bus.ex_opb},   32'd0);
        chk("rst.ex_op",    {29'd0, bus.ex_op},    32'd0);
        chk("rst.sb_busy",  {24'd0, bus.sb_busy},  32'd0);
        chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_instr = vecs[i].instr;
            #1;
            chk("vec.rf_read2", {31'd0, bus.rf_read2}, {31'd0, vecs[i].r2});
            chk("vec.rf_read3", {31'd0, bus.rf_read3}, {31'd0, vecs[i].r3});
            chk("vec.rf_adr2",  {29'd0, bus.rf_adr2},  {29'd0, vecs[i].instr[5:3]});
            chk("vec.rf_adr3",  {29'd0, bus.rf_adr3},  {29'd0, vecs[i].instr[2:0]});
            chk("vec.in_ready", {31'd0, bus.in_ready}, 32'd1);
            push(vecs[i].op, vecs[i].rd, vecs[i].wen, vecs[i].opa, vecs[i].opb);
            @(negedge clk);
            bus.in_valid = 1'b0;
            check_ex("vec");
            m = 8'h01;
            m = vecs[i].wen ? (m << vecs[i].rd) : 8'h00;
            chk("vec.sb_set", {24'd0, bus.sb_busy}, {24'd0, m});
            bus.wb_valid = vecs[i].wen;
            bus.wb_adr   = vecs[i].rd;
            @(negedge clk);
            bus.wb_valid = 1'b0;
            chk("vec.sb_clr",   {24'd0, bus.sb_busy},  32'd0);
            chk("vec.drained",  {31'd0, bus.ex_valid}, 32'd0);
        end

        // RAW on r3: stall persists through the wb cycle, issues the cycle after.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = 12'h2CA;
        push(3'd1, 3'd3, 1'b1, 12'h00A, 12'h005);
        @(negedge clk);
        check_ex("raw.add");
        bus.in_instr = 12'h559;
        #1;
        chk("raw.stall0", {31'd0, bus.in_ready}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("raw.stall", {31'd0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_adr   = 3'd3;
        #1;
        chk("raw.wb_cycle", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        chk("raw.release", {31'd0, bus.in_ready}, 32'd1);
        push(3'd2, 3'd5, 1'b1, 12'h333, 12'h00A);
        @(negedge clk);
        check_ex("raw.sub");
        chk("raw.sb", {24'd0, bus.sb_busy}, 32'h20);

        // Backpressure: ex held 3 cycles, next op loads as soon as ex_ready returns.
        bus.ex_ready = 1'b0;
        bus.in_instr = 12'hB3F;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp.ex_valid", {31'd0, bus.ex_valid}, 32'd1);
            chk("bp.ex_op",    {29'd0, bus.ex_op},    32'd2);
            chk("bp.ex_opa",   {20'd0, bus.ex_opa},   32'h333);
            chk("bp.ex_opb",   {20'd0, bus.ex_opb},   32'h00A);
            @(negedge clk);
        end
        bus.ex_ready = 1'b1;
        #1;
        chk("bp.resume", {31'd0, bus.in_ready}, 32'd1);
        push(3'd5, 3'd4, 1'b1, 12'h000, 12'h03F);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_ex("bp.ldi");
        chk("bp.sb", {24'd0, bus.sb_busy}, 32'h30);

        // Same-edge set and clear of r2: set wins; then clear of a non-pending r6.
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = 12'hA81;
        bus.wb_valid = 1'b1;
        bus.wb_adr   = 3'd2;
        #1;
        chk("sc.in_ready", {31'd0, bus.in_ready}, 32'd1);
        push(3'd5, 3'd2, 1'b1, 12'h000, 12'h001);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.wb_adr   = 3'd6;
        check_ex("sc.ldi");
        chk("sc.set_wins", {24'd0, bus.sb_busy}, 32'h04);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        chk("sc.nonpend", {24'd0, bus.sb_busy}, 32'h04);

        // Asynchronous reset while SUB is stalled with sb=8'h28.
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = 12'h2CA;
        push(3'd1, 3'd3, 1'b1, 12'h00A, 12'h005);
        @(negedge clk);
        check_ex("ar.add");
        bus.in_instr = 12'hB40;
        push(3'd5, 3'd5, 1'b1, 12'h000, 12'h000);
        @(negedge clk);
        check_ex("ar.ldi");
        bus.ex_ready = 1'b0;
        bus.in_instr = 12'h559;
        #1;
        chk("ar.stall", {31'd0, bus.in_ready}, 32'd0);
        chk("ar.sb",    {24'd0, bus.sb_busy},  32'h28);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar.ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("ar.sb_clear", {24'd0, bus.sb_busy},  32'd0);
        chk("ar.ex_rd",    {29'd0, bus.ex_rd},    32'd0);
        bus.in_valid = 1'b0;
        bus.ex_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar.in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("ar.queue", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
